lcd_sync_rx: RTL and testbench

Receive-side decoder for the LCD panel timing interface (HD, VD, DEN plus pixel data) driven by our LCD sync generator. It rebuilds the Fila/Columna coordinates of every active pixel and re-times the pixel data alongside them. It also measures line and frame geometry against the configured panel size and reports lock and timing errors. It is the bench-side and loopback-side checker for the display path, and the front end for any block that consumes an LCD-format video stream.

---
 rtl/lcd_sync_rx_if.sv | 33 +++
 rtl/lcd_sync_rx.sv | 132 +++++++++++++
 tb/tb_lcd_sync_rx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_sync_rx_if.sv
// LCD timing stream (HD/VD/DEN/pixel) plus the decoded coordinate and geometry
// results. The transmitter side is the master; the decoder is the slave.
interface lcd_sync_rx_if #(
  parameter int DW = 10
);
  logic          pix_en;
  logic          hd;
  logic          vd;
  logic          den;
  logic [DW-1:0] pix_in;
  logic [DW-1:0] pix_out;
  logic          pix_valid;
  logic [10:0]   columna;
  logic [9:0]    fila;
  logic          frame_start;
  logic [10:0]   line_len;
  logic [9:0]    frame_lines;
  logic          err_line;
  logic          err_frame;
  logic          locked;

  modport master (
    output pix_en, hd, vd, den, pix_in,
    input  pix_out, pix_valid, columna, fila, frame_start,
    input  line_len, frame_lines, err_line, err_frame, locked
  );

  modport slave (
    input  pix_en, hd, vd, den, pix_in,
    output pix_out, pix_valid, columna, fila, frame_start,
    output line_len, frame_lines, err_line, err_frame, locked
  );
endinterface

// File: rtl/lcd_sync_rx.sv
// LCD stream decoder: rebuilds Fila/Columna for each active pixel, measures
// line/frame geometry against the panel size and tracks lock.
//
// state   | meaning
// SEARCH  | waiting for a frame start, no geometry checks
// LOCKING | counting consecutive clean frames
// LOCKED  | geometry stable; any error drops back to SEARCH
module lcd_sync_rx #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int DW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input logic          clk,
  input logic          rst,
  lcd_sync_rx_if.slave bus
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0] H_N    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_N    = 10'(V_ACTIVE);
  localparam logic [GW:0] LOCK_N = (GW + 1)'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t        state, state_n;
  logic [GW-1:0] good_cnt, good_n;
  logic [GW:0]   good_inc;
  logic          hd_q, vd_q;
  logic [10:0]   col_cnt, col_base, col_next;
  logic [9:0]    line_cnt, lines_closed, row_base;
  logic [DW-1:0] pix_d;
  logic          line_det, frame_det, line_close, pixel;
  logic          err_line_det, err_frame_det, bad;

  assign pix_d     = bus.pix_in;
  assign line_det  = bus.pix_en & hd_q & ~bus.hd;
  assign frame_det = bus.pix_en & vd_q & ~bus.vd;
  assign pixel     = bus.pix_en & bus.den;

  // A frame start also closes any open line, so both clear the column count.
  assign line_close   = (line_det | frame_det) & (col_cnt != '0);
  assign col_base     = (line_det | frame_det) ? 11'd0 : col_cnt;
  assign col_next     = (pixel && col_base != 11'h7FF) ? col_base + 11'd1 : col_base;
  assign lines_closed = (line_close && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;
  assign row_base     = frame_det ? 10'd0 : lines_closed;

  assign err_line_det  = line_close & (col_cnt != H_N) & (state != SEARCH);
  assign err_frame_det = frame_det & (lines_closed != V_N) & (state != SEARCH);
  assign bad           = err_line_det | err_frame_det;
  assign good_inc      = {1'b0, good_cnt} + (GW + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    case (state)
      SEARCH: begin
        if (frame_det) begin
          state_n = LOCKING;
          good_n  = '0;
        end
      end
      LOCKING: begin
        if (bad) begin
          state_n = SEARCH;
          good_n  = '0;
        end else if (frame_det) begin
          good_n = good_inc[GW-1:0];
          if (good_inc >= LOCK_N) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_n = SEARCH;
          good_n  = '0;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_q            <= 1'b1;
      vd_q            <= 1'b1;
      col_cnt         <= '0;
      line_cnt        <= '0;
      bus.pix_out     <= '0;
      bus.pix_valid   <= 1'b0;
      bus.columna     <= '0;
      bus.fila        <= '0;
      bus.frame_start <= 1'b0;
      bus.line_len    <= '0;
      bus.frame_lines <= '0;
      bus.err_line    <= 1'b0;
      bus.err_frame   <= 1'b0;
      bus.locked      <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        hd_q     <= bus.hd;
        vd_q     <= bus.vd;
        col_cnt  <= col_next;
        line_cnt <= row_base;
      end
      bus.pix_valid <= pixel;
      if (pixel) begin
        bus.pix_out <= pix_d;
        bus.columna <= col_base;
        bus.fila    <= row_base;
      end
      bus.frame_start <= frame_det;
      bus.err_line    <= err_line_det;
      bus.err_frame   <= err_frame_det;
      if (line_close) bus.line_len <= col_cnt;
      if (frame_det) bus.frame_lines <= lines_closed;
      // Stay high through the error-pulse cycle so LOCKED falls one cycle later.
      bus.locked <= (state == LOCKED) | (state_n == LOCKED);
    end
  end
endmodule

// File: tb/tb_lcd_sync_rx.sv
// Directed bench for lcd_sync_rx on a reduced 8x6 panel: an event-level model
// predicts every output cycle, and literal checks pin key points of the model.
module tb_lcd_sync_rx;
  localparam int H    = 8;
  localparam int V    = 6;
  localparam int DW   = 10;
  localparam int LOCK = 2;
  localparam int HT   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_sync_rx_if #(.DW(DW)) bus ();

  lcd_sync_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DW(DW), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model: pixels in open line, lines closed in frame, lock phase, good frames
  int m_len = 0, m_lines = 0, m_st = 0, m_good = 0;

  logic          pend_valid = 0, pend_fs = 0, pend_el = 0, pend_ef = 0, pend_locked = 0;
  logic [DW-1:0] pend_pix = '0;
  int            pend_col = 0, pend_row = 0, pend_ll = 0, pend_fl = 0;
  logic          exp_valid = 0, exp_fs = 0, exp_el = 0, exp_ef = 0, exp_locked = 0;
  logic [DW-1:0] exp_pix = '0;
  int            exp_col = 0, exp_row = 0, exp_ll = 0, exp_fl = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    exp_valid = pend_valid; exp_fs = pend_fs; exp_el = pend_el; exp_ef = pend_ef;
    exp_locked = pend_locked; exp_pix = pend_pix; exp_col = pend_col;
    exp_row = pend_row; exp_ll = pend_ll; exp_fl = pend_fl;
    @(negedge clk);
    if (chk_en) begin
      chk("pix_valid", int'(bus.pix_valid), int'(exp_valid));
      if (exp_valid) begin
        chk("pix_out", int'(bus.pix_out), int'(exp_pix));
        chk("columna", int'(bus.columna), exp_col);
        chk("fila", int'(bus.fila), exp_row);
      end
      chk("frame_start", int'(bus.frame_start), int'(exp_fs));
      chk("err_line", int'(bus.err_line), int'(exp_el));
      chk("err_frame", int'(bus.err_frame), int'(exp_ef));
      chk("line_len", int'(bus.line_len), exp_ll);
      chk("frame_lines", int'(bus.frame_lines), exp_fl);
      chk("locked", int'(bus.locked), int'(exp_locked));
    end
  end

  // One CLK cycle of stimulus; ls/fs say whether this sample opens a line/frame.
  task automatic cyc(input bit en, input bit h, input bit v, input bit d,
                     input bit ls, input bit fs);
    logic [DW-1:0] px;
    bit was_locked;
    px = DW'($urandom);
    pend_valid = 0; pend_fs = 0; pend_el = 0; pend_ef = 0;
    was_locked = (m_st == 2);
    if (en) begin
      if ((ls || fs) && m_len > 0) begin
        pend_ll = m_len;
        pend_el = (m_st != 0) && (m_len != H);
        m_lines++;
        m_len = 0;
      end
      if (fs) begin
        pend_fl = m_lines;
        pend_ef = (m_st != 0) && (m_lines != V);
        pend_fs = 1;
        m_lines = 0;
      end
      if (m_st == 0) begin
        if (fs) begin m_st = 1; m_good = 0; end
      end else if (pend_el || pend_ef) begin
        m_st = 0;
      end else if (fs && m_st == 1) begin
        m_good++;
        if (m_good >= LOCK) m_st = 2;
      end
      if (d) begin
        pend_valid = 1; pend_pix = px; pend_col = m_len; pend_row = m_lines;
        m_len++;
      end
    end
    pend_locked = (m_st == 2) || was_locked;
    bus.pix_en = en; bus.hd = h; bus.vd = v; bus.den = d; bus.pix_in = px;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input bit h, input bit v, input bit d, input bit ls,
                      input bit fs, input int gap);
    int n;
    n = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(1, 5));
    repeat (n) cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    cyc(1'b1, h, v, d, ls, fs);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_out"}, int'(bus.pix_out), 0);
    chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_columna"}, int'(bus.columna), 0);
    chk({tag, "_fila"}, int'(bus.fila), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_line_len"}, int'(bus.line_len), 0);
    chk({tag, "_frame_lines"}, int'(bus.frame_lines), 0);
    chk({tag, "_err_line"}, int'(bus.err_line), 0);
    chk({tag, "_err_frame"}, int'(bus.err_frame), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; chk_en = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_len = 0; m_lines = 0; m_st = 0; m_good = 0;
    pend_valid = 0; pend_fs = 0; pend_el = 0; pend_ef = 0; pend_locked = 0;
    pend_pix = '0; pend_col = 0; pend_row = 0; pend_ll = 0; pend_fl = 0;
    @(posedge clk);
    #1;
    rst = 1'b0; chk_en = 1'b1;
  endtask

  // Hand-computed expectations at fixed points of the directed sequence.
  task automatic hook(input int fid, input int l, input int s);
    if (fid == 1 && l == 0 && s == 1) begin
      chk("first_pix_valid", int'(bus.pix_valid), 1);
      chk("first_pix_fila", int'(bus.fila), 0);
      chk("first_pix_col", int'(bus.columna), 0);
    end
    if (fid == 1 && l == V - 1 && s == H) begin
      chk("last_pix_fila", int'(bus.fila), V - 1);
      chk("last_pix_col", int'(bus.columna), H - 1);
    end
    if (fid == 2 && l == 0 && s == 0) begin
      chk("fs2_frame_start", int'(bus.frame_start), 1);
      chk("fs2_line_len", int'(bus.line_len), H);
      chk("fs2_frame_lines", int'(bus.frame_lines), V);
      chk("fs2_locked", int'(bus.locked), 0);
    end
    if (fid == 3 && l == 0 && s == 0) begin
      chk("fs3_locked", int'(bus.locked), 1);
      chk("fs3_err_frame", int'(bus.err_frame), 0);
    end
    if (fid == 5 && l == 3 && s == 0) begin
      chk("short_err_line", int'(bus.err_line), 1);
      chk("short_line_len", int'(bus.line_len), H - 1);
      chk("short_locked_hold", int'(bus.locked), 1);
    end
    if (fid == 5 && l == 3 && s == 1) begin
      chk("short_locked_drop", int'(bus.locked), 0);
      chk("short_err_once", int'(bus.err_line), 0);
    end
    if (fid == 8 && l == 0 && s == 0) chk("relock_locked", int'(bus.locked), 1);
    if (fid == 10 && l == 0 && s == 0) begin
      chk("coinc_valid", int'(bus.pix_valid), 1);
      chk("coinc_fila", int'(bus.fila), 0);
      chk("coinc_col", int'(bus.columna), 0);
      chk("coinc_line_len", int'(bus.line_len), H);
      chk("coinc_frame_lines", int'(bus.frame_lines), V);
      chk("coinc_err_line", int'(bus.err_line), 0);
    end
    if (fid == 13 && l == 0 && s == 0) begin
      chk("post_rst_err_frame", int'(bus.err_frame), 0);
      chk("post_rst_locked", int'(bus.locked), 0);
    end
    if (fid == 14 && l == 0 && s == 0) begin
      chk("shortf_err_frame", int'(bus.err_frame), 1);
      chk("shortf_frame_lines", int'(bus.frame_lines), V - 1);
      chk("shortf_locked", int'(bus.locked), 0);
    end
    if (fid == 14 && l == 0 && s == 1) chk("shortf_err_once", int'(bus.err_frame), 0);
  endtask

  // nl active lines then vb blank lines; HD and VD fall together on slot 0.
  task automatic frame(input int fid, input int nl, input int short_l, input bit den0,
                       input int gap, input int vb, input int rst_l, input int rst_c);
    for (int l = 0; l < nl + vb; l++) begin
      int first, len;
      first = (den0 && l == 0) ? 0 : 1;
      len   = (l == short_l) ? H - 1 : H;
      for (int s = 0; s < HT; s++) begin
        bit d;
        if (l == rst_l && s == first + rst_c) do_reset();
        d = (l < nl) && (s >= first) && (s < first + len);
        slot(s != 0, !(l == 0 && s == 0), d, s == 0, l == 0 && s == 0, gap);
        hook(fid, l, s);
      end
    end
  endtask

  initial begin
    bus.pix_en = 1'b0; bus.hd = 1'b1; bus.vd = 1'b1; bus.den = 1'b0; bus.pix_in = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0; chk_en = 1'b1;

    for (int f = 1; f <= 4; f++) frame(f, V, -1, 1'b0, 0, 2, -1, 0);
    frame(5, V, 2, 1'b0, 0, 2, -1, 0);
    frame(6, V, -1, 1'b0, 0, 2, -1, 0);
    frame(7, V, -1, 1'b0, 0, 2, -1, 0);
    frame(8, V, -1, 1'b0, 1, 2, -1, 0);
    frame(9, V, -1, 1'b0, 2, 0, -1, 0);
    frame(10, V, -1, 1'b1, 0, 2, -1, 0);
    frame(11, V, -1, 1'b0, 0, 2, 3, 4);
    frame(12, V, -1, 1'b0, 0, 2, -1, 0);
    frame(13, V - 1, -1, 1'b0, 0, 2, -1, 0);
    frame(14, V, -1, 1'b0, 0, 2, -1, 0);
    slot(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
